// File: rtl/clause_memory_loader.sv
// Clause store writer: packs incoming clauses into rows, commits them to an
// internal RAM, then streams the committed rows cyclically to the lanes.
module clause_memory_loader #(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  localparam int LIT_W    = VAR_ID_BITS + 1,
  localparam int CL_W     = LIT_W * NUM_VARS_PER_CLAUSE,
  localparam int ROW_W    = CL_W * NUM_CLAUSES_PER_CYCLE,
  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int RP_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CL_W-1:0]   in_clause,
  input  logic              load_done,
  input  logic              clear,
  output logic [ROW_W-1:0]  output_memory_slice,
  output logic              slice_valid,
  output logic [RP_W-1:0]   row_ptr,
  output logic [RP_W:0]     num_rows,
  output logic              overflow
);

  localparam int CP_W = (NUM_CLAUSES_PER_CYCLE > 1) ? $clog2(NUM_CLAUSES_PER_CYCLE) : 1;
  localparam int CC_W = $clog2(NUM_CLAUSES + 1);

  typedef enum logic [1:0] {LOAD, FLUSH, STREAM} state_t;

  state_t            state;
  logic [CP_W-1:0]   col_ptr;
  logic [CC_W-1:0]   clause_count;
  logic [RP_W:0]     wr_row;
  logic [RP_W-1:0]   rd_ptr;
  logic [ROW_W-1:0]  row_buf;
  logic [ROW_W-1:0]  row_next;
  logic [ROW_W-1:0]  mem [NUM_ROWS];

  logic              accept;
  logic              lane_last;
  logic              mem_we;
  logic [RP_W-1:0]   mem_addr;
  logic [ROW_W-1:0]  mem_data;

  assign in_ready  = (state == LOAD) && (clause_count < CC_W'(NUM_CLAUSES));
  assign accept    = in_valid & in_ready;
  assign lane_last = (col_ptr == CP_W'(NUM_CLAUSES_PER_CYCLE - 1));

  // Row buffer with the incoming clause merged into lane col_ptr.
  always_comb begin
    row_next = row_buf;
    row_next[int'(col_ptr)*CL_W +: CL_W] = in_clause;
  end

  // RAM write port: full row commit during LOAD, padded partial row in FLUSH.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_row[RP_W-1:0];
    mem_data = row_buf;
    if (!rst && !clear) begin
      case (state)
        LOAD: if (accept && lane_last) begin
          mem_we   = 1'b1;
          mem_data = row_next;
        end
        FLUSH: if (col_ptr != '0) mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Clause RAM storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  // Load / flush / stream control with registered outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state               <= LOAD;
      col_ptr             <= '0;
      clause_count        <= '0;
      wr_row              <= '0;
      rd_ptr              <= '0;
      row_buf             <= '0;
      output_memory_slice <= '0;
      slice_valid         <= 1'b0;
      row_ptr             <= '0;
      num_rows            <= '0;
      overflow            <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            clause_count <= clause_count + 1'b1;
            if (lane_last) begin
              col_ptr <= '0;
              row_buf <= '0;
              wr_row  <= wr_row + 1'b1;
            end else begin
              col_ptr <= col_ptr + 1'b1;
              row_buf <= row_next;
            end
          end
          if (in_valid && !in_ready) overflow <= 1'b1;
          // A beat accepted alongside load_done is counted before leaving.
          if (load_done && (accept || clause_count != '0)) state <= FLUSH;
        end
        FLUSH: begin
          if (col_ptr != '0) begin
            wr_row   <= wr_row + 1'b1;
            num_rows <= wr_row + 1'b1;
            col_ptr  <= '0;
            row_buf  <= '0;
          end else begin
            num_rows <= wr_row;
          end
          rd_ptr <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          output_memory_slice <= mem[rd_ptr];
          row_ptr             <= rd_ptr;
          slice_valid         <= 1'b1;
          rd_ptr <= ({1'b0, rd_ptr} == num_rows - 1'b1) ? '0 : rd_ptr + 1'b1;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_memory_loader.sv
// Scoreboard bench for clause_memory_loader: the driver loads clauses and
// queues the expected slice sequence; a monitor pops and compares each slice.
module tb_clause_memory_loader;

  localparam int NC       = 64;
  localparam int VB       = 8;
  localparam int NPC      = 16;
  localparam int NV       = 3;
  localparam int LIT_W    = VB + 1;
  localparam int CL_W     = LIT_W * NV;
  localparam int ROW_W    = CL_W * NPC;
  localparam int NUM_ROWS = NC / NPC;
  localparam int RP_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CL_W-1:0]   in_clause;
  logic              load_done;
  logic              clear;
  logic [ROW_W-1:0]  output_memory_slice;
  logic              slice_valid;
  logic [RP_W-1:0]   row_ptr;
  logic [RP_W:0]     num_rows;
  logic              overflow;

  clause_memory_loader #(
    .NUM_CLAUSES(NC),
    .VAR_ID_BITS(VB),
    .NUM_CLAUSES_PER_CYCLE(NPC),
    .NUM_VARS_PER_CLAUSE(NV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_clause(in_clause),
    .load_done(load_done),
    .clear(clear),
    .output_memory_slice(output_memory_slice),
    .slice_valid(slice_valid),
    .row_ptr(row_ptr),
    .num_rows(num_rows),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RP_W-1:0]  rp;
    logic [ROW_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   load_vals[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CL_W-1:0] cl(input int v);
    logic [LIT_W-1:0] lit;
    lit = {1'b0, VB'(v)};
    return {lit, lit, lit};
  endfunction

  // Expected row r of the current load: clause r*NPC+l in lane l, zero past the end.
  function automatic logic [ROW_W-1:0] exp_row(input int r);
    logic [ROW_W-1:0] row;
    row = '0;
    for (int l = 0; l < NPC; l++) begin
      if (r * NPC + l < load_vals.size())
        row[l*CL_W +: CL_W] = cl(load_vals[r*NPC + l]);
    end
    return row;
  endfunction

  // Monitor: every valid slice with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (slice_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("row_ptr", ROW_W'(row_ptr), ROW_W'(e.rp));
        chk("slice", output_memory_slice, e.data);
      end
    end
  end

  task automatic load(input int n, input int base, input bit gaps, input bit ld_last);
    load_vals.delete();
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      load_vals.push_back(base + k + 1);
      in_valid  = 1'b1;
      in_clause = cl(base + k + 1);
      load_done = ld_last && (k == n - 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      load_done = 1'b0;
    end
  endtask

  task automatic pulse_ld();
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, ROW_W'(in_ready), ROW_W'(1));
    chk({nm, "_slice_valid"}, ROW_W'(slice_valid), '0);
    chk({nm, "_slice"}, output_memory_slice, '0);
    chk({nm, "_row_ptr"}, ROW_W'(row_ptr), '0);
    chk({nm, "_num_rows"}, ROW_W'(num_rows), '0);
    chk({nm, "_overflow"}, ROW_W'(overflow), '0);
  endtask

  task automatic do_clear(input string nm);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_reset(nm);
  endtask

  // Called one step after the load_done edge (DUT in FLUSH).
  task automatic expect_stream(input string nm, input int nrows, input int nslices);
    exp_t e;
    for (int i = 0; i < nslices; i++) begin
      e.rp   = RP_W'(i % nrows);
      e.data = exp_row(i % nrows);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    chk({nm, "_flush_valid"}, ROW_W'(slice_valid), '0);
    chk({nm, "_num_rows"}, ROW_W'(num_rows), ROW_W'(nrows));
    @(posedge clk); #1;
    chk({nm, "_first_valid"}, ROW_W'(slice_valid), ROW_W'(1));
    repeat (nslices) @(negedge clk);
    #1;
    chk({nm, "_no_bubble"}, ROW_W'(sb.size()), '0);
    chk({nm, "_still_valid"}, ROW_W'(slice_valid), ROW_W'(1));
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_clause = '0; load_done = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Full load of 64 clauses, stream wraps 0..3,0,1.
    load(64, 0, 1'b0, 1'b0);
    chk("full_in_ready", ROW_W'(in_ready), '0);
    pulse_ld();
    expect_stream("full", 4, 6);
    do_clear("clear1");

    // Partial load of 20 clauses: second row padded with zeros.
    load(20, 0, 1'b0, 1'b0);
    pulse_ld();
    expect_stream("partial", 2, 4);
    do_clear("clear2");

    // Overflow: beats offered while full are dropped and flagged.
    load(64, 0, 1'b0, 1'b0);
    chk("ovf_in_ready", ROW_W'(in_ready), '0);
    in_valid  = 1'b1;
    in_clause = cl(200);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ovf_set", ROW_W'(overflow), ROW_W'(1));
    @(posedge clk); #1;
    chk("ovf_sticky", ROW_W'(overflow), ROW_W'(1));
    pulse_ld();
    expect_stream("ovf", 4, 6);
    chk("ovf_stream", ROW_W'(overflow), ROW_W'(1));
    do_clear("clear3");

    // Gapped load of 40 clauses with load_done on the final beat.
    load(40, 0, 1'b1, 1'b1);
    expect_stream("gaps", 3, 4);
    do_clear("clear4");

    // load_done with nothing loaded stays in LOAD.
    pulse_ld();
    repeat (2) @(posedge clk);
    #1;
    chk("empty_in_ready", ROW_W'(in_ready), ROW_W'(1));
    chk("empty_valid", ROW_W'(slice_valid), '0);
    chk("empty_num_rows", ROW_W'(num_rows), '0);

    // Clear in the middle of a stream, then a single-row reload.
    load(30, 0, 1'b0, 1'b0);
    pulse_ld();
    expect_stream("pre_clear", 2, 2);
    do_clear("clear_stream");
    load(16, 10, 1'b0, 1'b0);
    pulse_ld();
    expect_stream("reload16", 1, 3);
    do_clear("clear5");

    // Reset after 10 beats; the discarded buffer must not leak into a 5-clause reload.
    load(10, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("rst_load");
    load(5, 70, 1'b0, 1'b0);
    pulse_ld();
    expect_stream("reload5", 1, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
